// File: rtl/edf_ic_pkg.sv
// Shared types and constants for the EDF interrupt arbiter slice.
// The accumulator struct is sized for the default build; instances may shrink NumIrq/TsWidth but not exceed them.
package edf_ic_pkg;

    localparam int NumIrqDef  = 8;
    localparam int TsWidthDef = 64;
    localparam int AccIdWidth = $clog2(NumIrqDef);
    localparam int AccDlWidth = TsWidthDef;

    typedef enum logic [0:0] {
        SCAN  = 1'b0,
        FLUSH = 1'b1
    } edf_state_e;

    typedef struct packed {
        logic                  valid;
        logic [AccIdWidth-1:0] id;
        logic [AccDlWidth-1:0] dl;
    } edf_acc_t;

    localparam edf_acc_t AccEmpty = '{valid: 1'b0, id: '0, dl: '0};

    // Strict unsigned earlier-than; equal deadlines keep the incumbent (lower index).
    function automatic logic dl_before(input logic [AccDlWidth-1:0] cand,
                                       input logic [AccDlWidth-1:0] best);
        return (cand < best);
    endfunction

endpackage

// File: rtl/edf_arbiter_if.sv
// Gateway-array / hart side bundle of the EDF arbiter; clock and reset stay outside.
interface edf_arbiter_if #(
    parameter int NumIrq  = 8,
    parameter int TsWidth = 64,
    parameter int IdWidth = $clog2(NumIrq)
) ();

    logic [63:0]             mtime_i;
    logic [NumIrq-1:0]       ip_i;
    logic [NumIrq*TsWidth-1:0] dl_i;
    logic [NumIrq-1:0]       claim_o;
    logic                    irq_o;
    logic [IdWidth-1:0]      irq_id_o;
    logic [TsWidth-1:0]      irq_dl_o;
    logic                    dl_miss_o;
    logic                    claim_req_i;
    logic                    claim_rsp_valid_o;
    logic                    claim_rsp_hit_o;
    logic [IdWidth-1:0]      claim_rsp_id_o;

    modport master (
        output mtime_i, ip_i, dl_i, claim_req_i,
        input  claim_o, irq_o, irq_id_o, irq_dl_o, dl_miss_o,
        input  claim_rsp_valid_o, claim_rsp_hit_o, claim_rsp_id_o
    );

    modport slave (
        input  mtime_i, ip_i, dl_i, claim_req_i,
        output claim_o, irq_o, irq_id_o, irq_dl_o, dl_miss_o,
        output claim_rsp_valid_o, claim_rsp_hit_o, claim_rsp_id_o
    );

endinterface

// File: rtl/edf_scan_acc.sv
// Earliest-deadline accumulator: folds one candidate per cycle into the running best.
// acc_o is this cycle's merged result, so a commit can include the final candidate.
module edf_scan_acc
    import edf_ic_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  cand_ip_i,
    input  logic [AccIdWidth-1:0] cand_id_i,
    input  logic [AccDlWidth-1:0] cand_dl_i,
    output edf_acc_t              acc_o
);

    edf_acc_t acc_r;
    edf_acc_t acc_nxt_s;

    // Merge the candidate into the running best.
    always_comb begin
        acc_nxt_s = acc_r;
        if (cand_ip_i && (!acc_r.valid || dl_before(cand_dl_i, acc_r.dl))) begin
            acc_nxt_s.valid = 1'b1;
            acc_nxt_s.id    = cand_id_i;
            acc_nxt_s.dl    = cand_dl_i;
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Accumulator register; clear wins over the merge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_r <= AccEmpty;
        end else if (clear_i) begin
            acc_r <= AccEmpty;
        end else begin
            acc_r <= acc_nxt_s;
        end
    end

    assign acc_o = acc_nxt_s;

endmodule

// File: rtl/edf_arbiter.sv
// EDF interrupt arbiter: sweeps the gateway cells one per cycle, commits the
// earliest pending deadline to the hart and serves claim requests.
module edf_arbiter
    import edf_ic_pkg::*;
#(
    parameter int NumIrq  = NumIrqDef,
    parameter int TsWidth = TsWidthDef,
    parameter int IdWidth = $clog2(NumIrq)
) (
    input logic          clk_i,
    input logic          rst_i,
    edf_arbiter_if.slave bus
);

    edf_state_e          state_r, state_nxt_s;
    logic [IdWidth-1:0]  idx_r, idx_nxt_s;
    logic                irq_r, irq_nxt_s;
    logic [IdWidth-1:0]  irq_id_r, irq_id_nxt_s;
    logic [TsWidth-1:0]  irq_dl_r, irq_dl_nxt_s;
    logic [NumIrq-1:0]   claim_r, claim_nxt_s;
    logic                rsp_valid_r, rsp_valid_nxt_s;
    logic                rsp_hit_r, rsp_hit_nxt_s;
    logic [IdWidth-1:0]  rsp_id_r, rsp_id_nxt_s;

    logic                last_s;
    logic                acc_clr_s;
    logic                cand_ip_s;
    logic [AccIdWidth-1:0] cand_id_s;
    logic [AccDlWidth-1:0] cand_dl_s;
    logic [TsWidth-1:0]  mtime_s;
    edf_acc_t            acc_s;

    assign last_s    = (idx_r == IdWidth'(NumIrq - 1));
    assign cand_ip_s = bus.ip_i[idx_r];
    assign cand_id_s = AccIdWidth'(idx_r);
    assign cand_dl_s = AccDlWidth'(bus.dl_i[int'(idx_r) * TsWidth +: TsWidth]);
    assign mtime_s   = TsWidth'(bus.mtime_i);

    edf_scan_acc u_scan_acc (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (acc_clr_s),
        .cand_ip_i (cand_ip_s),
        .cand_id_i (cand_id_s),
        .cand_dl_i (cand_dl_s),
        .acc_o     (acc_s)
    );

    // Next-state, commit and claim response logic.
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        acc_clr_s       = 1'b0;
        irq_nxt_s       = irq_r;
        irq_id_nxt_s    = irq_id_r;
        irq_dl_nxt_s    = irq_dl_r;
        claim_nxt_s     = '0;
        rsp_valid_nxt_s = 1'b0;
        rsp_hit_nxt_s   = 1'b0;
        rsp_id_nxt_s    = '0;
        case (state_r)
            SCAN: begin
                if (bus.claim_req_i && irq_r) begin
                    // Accepted claim: hand out the committed winner and drop the partial sweep.
                    claim_nxt_s     = NumIrq'(1'b1) << irq_id_r;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_hit_nxt_s   = 1'b1;
                    rsp_id_nxt_s    = irq_id_r;
                    irq_nxt_s       = 1'b0;
                    state_nxt_s     = FLUSH;
                    idx_nxt_s       = '0;
                    acc_clr_s       = 1'b1;
                end else begin
                    rsp_valid_nxt_s = bus.claim_req_i;
                    if (last_s) begin
                        irq_nxt_s    = acc_s.valid;
                        irq_id_nxt_s = IdWidth'(acc_s.id);
                        irq_dl_nxt_s = TsWidth'(acc_s.dl);
                        idx_nxt_s    = '0;
                        acc_clr_s    = 1'b1;
                    end else begin
                        idx_nxt_s    = idx_r + IdWidth'(1'b1);
                    end
                end
            end
            FLUSH: begin
                rsp_valid_nxt_s = bus.claim_req_i;
                state_nxt_s     = SCAN;
                idx_nxt_s       = '0;
                acc_clr_s       = 1'b1;
            end
            default: begin
                state_nxt_s = SCAN;
                idx_nxt_s   = '0;
                acc_clr_s   = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= SCAN;
            idx_r       <= '0;
            irq_r       <= 1'b0;
            irq_id_r    <= '0;
            irq_dl_r    <= '0;
            claim_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_id_r    <= '0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            irq_r       <= irq_nxt_s;
            irq_id_r    <= irq_id_nxt_s;
            irq_dl_r    <= irq_dl_nxt_s;
            claim_r     <= claim_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_hit_r   <= rsp_hit_nxt_s;
            rsp_id_r    <= rsp_id_nxt_s;
        end
    end

    assign bus.claim_o           = claim_r;
    assign bus.irq_o             = irq_r;
    assign bus.irq_id_o          = irq_id_r;
    assign bus.irq_dl_o          = irq_dl_r;
    assign bus.dl_miss_o         = irq_r && (irq_dl_r < mtime_s);
    assign bus.claim_rsp_valid_o = rsp_valid_r;
    assign bus.claim_rsp_hit_o   = rsp_hit_r;
    assign bus.claim_rsp_id_o    = rsp_id_r;

endmodule

// File: tb/tb_edf_arbiter.sv
// Directed bench for edf_arbiter: steady-state vector table plus claim/reset sequences.
module tb_edf_arbiter;

    localparam int N  = 8;
    localparam int TW = 64;

    typedef struct {
        logic [N-1:0]         ip;
        logic [N-1:0][TW-1:0] dl;
        logic [63:0]          mtime;
        logic                 exp_irq;
        logic [2:0]           exp_id;
        logic [63:0]          exp_dl;
        logic                 exp_miss;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[9];
    logic [N-1:0][TW-1:0] dlv;

    always #5 clk = ~clk;

    edf_arbiter_if #(.NumIrq(N), .TsWidth(TW)) bus ();

    edf_arbiter #(.NumIrq(N), .TsWidth(TW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_irq"},   64'(bus.irq_o), 64'd0);
        chk({tag, "_id"},    64'(bus.irq_id_o), 64'd0);
        chk({tag, "_dl"},    bus.irq_dl_o, 64'd0);
        chk({tag, "_miss"},  64'(bus.dl_miss_o), 64'd0);
        chk({tag, "_claim"}, 64'(bus.claim_o), 64'd0);
        chk({tag, "_rspv"},  64'(bus.claim_rsp_valid_o), 64'd0);
        chk({tag, "_rsph"},  64'(bus.claim_rsp_hit_o), 64'd0);
        chk({tag, "_rspid"}, 64'(bus.claim_rsp_id_o), 64'd0);
    endtask

    initial begin
        int n;
        int pulses;

        for (int i = 0; i < 9; i++) vecs[i] = '{default: '0};
        // idle
        vecs[0].mtime = 64'd100;
        // basic pick; masked source 0 has an earlier deadline but is not pending
        vecs[1].ip = 8'b0010_0101; vecs[1].ip[0] = 1'b0;
        vecs[1].dl[0] = 64'd1; vecs[1].dl[2] = 64'd100; vecs[1].dl[5] = 64'd40;
        vecs[1].mtime = 64'd39; vecs[1].exp_irq = 1'b1; vecs[1].exp_id = 3'd5; vecs[1].exp_dl = 64'd40;
        vecs[2] = vecs[1]; vecs[2].mtime = 64'd41; vecs[2].exp_miss = 1'b1;
        // tie -> lower index
        vecs[3].ip = 8'b0100_0010; vecs[3].dl[1] = 64'd77; vecs[3].dl[6] = 64'd77;
        vecs[3].exp_irq = 1'b1; vecs[3].exp_id = 3'd1; vecs[3].exp_dl = 64'd77;
        // all-ones tie at the extremes; equal mtime is not a miss
        vecs[4].ip = 8'b1000_0001; vecs[4].dl[0] = '1; vecs[4].dl[7] = '1; vecs[4].mtime = '1;
        vecs[4].exp_irq = 1'b1; vecs[4].exp_id = 3'd0; vecs[4].exp_dl = '1;
        // last index wins with deadline 0
        vecs[5].ip = 8'b1000_0001; vecs[5].dl[0] = 64'd5; vecs[5].dl[7] = 64'd0; vecs[5].mtime = 64'd1;
        vecs[5].exp_irq = 1'b1; vecs[5].exp_id = 3'd7; vecs[5].exp_dl = 64'd0; vecs[5].exp_miss = 1'b1;
        // everything pending, minimum in the middle
        vecs[6].ip = 8'hFF;
        for (int k = 0; k < N; k++) vecs[6].dl[k] = 64'(50 + 10 * k);
        vecs[6].dl[3] = 64'd10; vecs[6].mtime = 64'd10;
        vecs[6].exp_irq = 1'b1; vecs[6].exp_id = 3'd3; vecs[6].exp_dl = 64'd10;
        // full-width unsigned compare, no wrap handling
        vecs[7].ip = 8'b0001_0010; vecs[7].dl[1] = 64'h8000_0000_0000_0000; vecs[7].dl[4] = 64'h7FFF_FFFF_FFFF_FFFF;
        vecs[7].mtime = 64'h8000_0000_0000_0000;
        vecs[7].exp_irq = 1'b1; vecs[7].exp_id = 3'd4; vecs[7].exp_dl = 64'h7FFF_FFFF_FFFF_FFFF; vecs[7].exp_miss = 1'b1;
        // back to idle with stale deadlines and a large mtime
        vecs[8].dl[0] = 64'd1; vecs[8].mtime = '1;

        // reset
        rst = 1'b1; bus.claim_req_i = 1'b0; bus.ip_i = '0; bus.dl_i = '0; bus.mtime_i = 64'd0;
        repeat (3) step();
        chk_all_zero("reset");
        rst = 1'b0;

        // idle sweeps, then a claim with nothing to claim
        repeat (3 * N) step();
        chk("idle_irq", 64'(bus.irq_o), 64'd0);
        bus.claim_req_i = 1'b1;
        step();
        bus.claim_req_i = 1'b0;
        chk("idle_rspv", 64'(bus.claim_rsp_valid_o), 64'd1);
        chk("idle_rsph", 64'(bus.claim_rsp_hit_o), 64'd0);
        chk("idle_rspid", 64'(bus.claim_rsp_id_o), 64'd0);
        chk("idle_claim", 64'(bus.claim_o), 64'd0);
        step();
        chk("idle_rspv_end", 64'(bus.claim_rsp_valid_o), 64'd0);

        // steady-state table
        for (int i = 0; i < 9; i++) begin
            bus.ip_i = vecs[i].ip; bus.dl_i = vecs[i].dl; bus.mtime_i = vecs[i].mtime;
            repeat (2 * N) step();
            chk($sformatf("v%0d_irq", i), 64'(bus.irq_o), 64'(vecs[i].exp_irq));
            if (vecs[i].exp_irq) begin
                chk($sformatf("v%0d_id", i), 64'(bus.irq_id_o), 64'(vecs[i].exp_id));
                chk($sformatf("v%0d_dl", i), bus.irq_dl_o, vecs[i].exp_dl);
            end else begin
                chk($sformatf("v%0d_miss_idle", i), 64'(bus.dl_miss_o), 64'd0);
            end
            chk($sformatf("v%0d_miss", i), 64'(bus.dl_miss_o), 64'(vecs[i].exp_miss));
            chk($sformatf("v%0d_claim", i), 64'(bus.claim_o), 64'd0);
        end

        // claim path: winner 5, then gateway drops ip[5]
        dlv = '0; dlv[2] = 64'd100; dlv[5] = 64'd40;
        bus.ip_i = 8'b0010_0100; bus.dl_i = dlv; bus.mtime_i = 64'd0;
        repeat (2 * N) step();
        chk("cp_pre_id", 64'(bus.irq_id_o), 64'd5);
        bus.claim_req_i = 1'b1;
        step();
        bus.claim_req_i = 1'b0;
        chk("cp_claim", 64'(bus.claim_o), 64'h20);
        chk("cp_rspv", 64'(bus.claim_rsp_valid_o), 64'd1);
        chk("cp_rsph", 64'(bus.claim_rsp_hit_o), 64'd1);
        chk("cp_rspid", 64'(bus.claim_rsp_id_o), 64'd5);
        chk("cp_irq_clr", 64'(bus.irq_o), 64'd0);
        bus.ip_i = 8'b0000_0100;
        step();
        chk("cp_claim_once", 64'(bus.claim_o), 64'd0);
        chk("cp_rspv_once", 64'(bus.claim_rsp_valid_o), 64'd0);
        n = 0;
        while (!bus.irq_o && n < 20) begin step(); n++; end
        chk("cp_recommit_lat", 64'(n), 64'd8);
        chk("cp_next_id", 64'(bus.irq_id_o), 64'd2);
        chk("cp_next_dl", bus.irq_dl_o, 64'd100);

        // held claim for three cycles with winner 2
        pulses = 0;
        bus.claim_req_i = 1'b1;
        step();
        pulses += (bus.claim_o != '0) ? 1 : 0;
        chk("hold1_claim", 64'(bus.claim_o), 64'h04);
        chk("hold1_rsph", 64'(bus.claim_rsp_hit_o), 64'd1);
        chk("hold1_rspid", 64'(bus.claim_rsp_id_o), 64'd2);
        bus.ip_i = '0;
        step();
        pulses += (bus.claim_o != '0) ? 1 : 0;
        chk("hold2_rspv", 64'(bus.claim_rsp_valid_o), 64'd1);
        chk("hold2_rsph", 64'(bus.claim_rsp_hit_o), 64'd0);
        chk("hold2_rspid", 64'(bus.claim_rsp_id_o), 64'd0);
        step();
        pulses += (bus.claim_o != '0) ? 1 : 0;
        bus.claim_req_i = 1'b0;
        chk("hold3_rspv", 64'(bus.claim_rsp_valid_o), 64'd1);
        chk("hold3_rsph", 64'(bus.claim_rsp_hit_o), 64'd0);
        chk("hold_pulses", 64'(pulses), 64'd1);

        // reset mid-sweep with a claim in flight
        dlv = '0; dlv[3] = 64'd5;
        bus.ip_i = 8'b0000_1000; bus.dl_i = dlv; bus.mtime_i = 64'd100;
        repeat (2 * N) step();
        chk("rst_pre_irq", 64'(bus.irq_o), 64'd1);
        repeat (3) step();
        rst = 1'b1; bus.claim_req_i = 1'b1;
        step();
        chk_all_zero("rst_mid");
        rst = 1'b0; bus.claim_req_i = 1'b0;
        n = 0;
        while (!bus.irq_o && n < 20) begin step(); n++; end
        chk("rst_resweep_lat", 64'(n), 64'd8);
        chk("rst_resweep_id", 64'(bus.irq_id_o), 64'd3);
        chk("rst_resweep_miss", 64'(bus.dl_miss_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edf_arbiter.md
Name: edf_arbiter

Overview:
- Consumer end of the gateway-cell interface. Takes NumIrq pending flags and their absolute deadlines, and sequentially scans them to find the pending source with the earliest deadline.
- Presents that winner to the hart as irq_o, irq_id_o and irq_dl_o.
- Serves hart claim requests by returning the winner ID and pulsing the matching per-source claim line back to that gateway cell.
- Sits between the gateway-cell array and the hart interrupt input.

Parameters:
- NumIrq, 8, number of gateway cells (sources 0..NumIrq-1); must be >= 2.
- TsWidth, 64, deadline width; must match the gateway deadline width.
- IdWidth, $clog2(NumIrq), width of a source index.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- mtime_i  in  64  current machine time, used for deadline-miss detection
- ip_i  in  NumIrq  per-source pending flag from the gateway cells
- dl_i  in  NumIrq*TsWidth  per-source deadline, flattened; source k occupies bits [k*TsWidth +: TsWidth]
- claim_o  out  NumIrq  one-hot, single-cycle claim pulse to a gateway cell
- irq_o  out  1  a committed winner is valid
- irq_id_o  out  IdWidth  committed winner index
- irq_dl_o  out  TsWidth  committed winner deadline
- dl_miss_o  out  1  irq_o && (irq_dl_o < mtime_i)
- claim_req_i  in  1  hart claim request, sampled every cycle
- claim_rsp_valid_o  out  1  claim response strobe, one cycle
- claim_rsp_hit_o  out  1  response carries a real source (0 = nothing to claim)
- claim_rsp_id_o  out  IdWidth  claimed source index, 0 when hit=0

Behaviour:
- Reset, when rst_i=1 at a clock edge, sets:
  - all outputs to 0;
  - scan index to 0, accumulator empty;
  - state to SCAN.
- Interface rule: only clk_i and rst_i are shared; the arbiter does not reuse other gateway-cell signals.
- State SCAN, one source per cycle:
  - At index k, if ip_i[k]=1 and either the accumulator is empty or dl_i[k] < the accumulated deadline, load k and dl_i[k] into the accumulator.
  - The comparison is a strict, unsigned, full-TsWidth less-than with no wrap handling. On equal deadlines the lower index wins.
  - At k = NumIrq-1, after that cycle's compare, commit the accumulator to irq_o/irq_id_o/irq_dl_o. irq_o=0 if nothing was pending.
  - After commit, clear the accumulator and set the index to 0; scanning is continuous.
  - Commit latency: NumIrq cycles per sweep. A newly pending source is visible on irq_o at most 2*NumIrq cycles after ip_i rises.
- Claim accepted: claim_req_i=1 in SCAN with irq_o=1 at cycle t. Then at t+1:
  - claim_o[irq_id_o] pulses for exactly one cycle;
  - claim_rsp_valid_o=1, claim_rsp_hit_o=1, claim_rsp_id_o = winner;
  - irq_o clears to 0;
  - state moves to FLUSH.
- Claim with nothing pending: claim_req_i=1 with irq_o=0 (in SCAN or FLUSH). At t+1, claim_rsp_valid_o=1 with hit=0 and id=0. No claim_o pulse, and the scan is not disturbed.
- State FLUSH, entered at t+1:
  - Lasts one cycle, which covers the gateway's registered ip clear.
  - Then scanning restarts at index 0 with an empty accumulator, starting at t+2.
  - Any partial sweep in progress at t is discarded.
- Held claim_req_i: each cycle is a separate request. The cycle after an accepted claim falls in FLUSH, so it returns hit=0.
- Stale winner: the committed winner is not rechecked against ip_i. A claim returns the last committed winner.
- dl_miss_o is combinational from registered outputs and mtime_i. mtime_i is zero-extended or truncated to TsWidth.
- Reset mid-sweep or in FLUSH: discard all state and restart in SCAN at index 0. A pending claim_o or response is dropped.

Decomposition:
- Shared package edf_ic_pkg holds:
  - the state enum {SCAN, FLUSH};
  - default constants NumIrqDef=8 and TsWidthDef=64;
  - a struct {valid, id, dl} used for both the accumulator and the committed result.
- One natural sub-module, edf_scan_acc: the per-cycle compare/accumulate unit. It takes a candidate (ip, k, dl) plus a clear input and produces the accumulator struct. The arbiter keeps the FSM, the index counter, commit and claim logic.

Test Plan:
- Reset, then idle (ip_i=0) for 3 sweeps -> irq_o=0; claim_req pulse -> rsp_valid=1, hit=0, id=0, claim_o=0.
- ip_i[2]=1 with dl=100, ip_i[5]=1 with dl=40 -> after at most 16 cycles irq_o=1, irq_id_o=5, irq_dl_o=40.
- Tie: ip[1] and ip[6] both with dl=77 -> irq_id_o=1.
- Claim path: with winner 5, claim_req at t -> claim_o=8'b0010_0000 at t+1 only, with rsp hit=1 and id=5. Bench model drops ip[5] at t+2. Next commit is id=2, dl=100.
- claim_req held for 3 cycles with winner 2 -> responses hit=1/id=2, then hit=0, then hit=0 until the next commit; exactly one claim_o pulse.
- Deadline miss: winner dl=40 with mtime_i=39, then 41 -> dl_miss_o goes 0, then 1.
- Reset asserted mid-sweep -> all outputs 0 the next cycle; a full re-sweep is needed before irq_o=1.
